sram_arbiter_ctrl: RTL

//  Two-port arbiter/sequencer sharing the single 16-bit external SRAM between requesters
//  (port 0: pipeline MEM stage, port 1: secondary master, e.g. loader/DMA).

---
 rtl/sram_arbiter_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter_ctrl.sv
// rtl/sram_arbiter_ctrl.sv - two-port round-robin sequencer for a shared 16-bit SRAM
//
// Purpose:
//   Shares one 16-bit asynchronous SRAM between two 32-bit requesters.
//   Port 0 is the pipeline MEM stage and port 1 is a secondary master such as
//   a loader or DMA engine. Each 32-bit access is split into two SRAM phases:
//   the low half-word first, then the high half-word. Each phase is held for
//   WAIT_CYCLES+1 cycles. A requester stalls until its one-cycle ready pulse.
//
// Parameters:
//   BASE_ADDR    byte address that maps to SRAM word 0
//   WAIT_CYCLES  extra cycles each SRAM phase is held
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   m0_req/m0_we            port 0 request (held until ready) and write flag
//   m0_addr/m0_wdata        port 0 byte address ([1:0] ignored) and write data
//   m0_rdata/m0_ready       port 0 read data (valid with ready) and completion pulse
//   m1_*                    the same set of signals for port 1
//   busy                    high whenever the sequencer is not idle
//   SRAM_ADDR/SRAM_DQ       SRAM half-word address and bidirectional data
//   SRAM_WE_N               SRAM write enable (active low)
//   SRAM_UB_N/LB_N/CE_N/OE_N  SRAM byte, chip and output enables, tied active

module sram_arbiter_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        busy,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;          // port that owns the current access
  logic          last_grant_q, last_grant_d;
  logic          we_q, we_d;
  logic [16:0]   word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   rd_lo_q, rd_lo_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;

  // Request selection: on a tie the port that did not win last time is taken.
  logic        any_req;
  logic        pick;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] addr_off;
  logic [16:0] sel_word;
  logic        unused_addr_bits;

  assign any_req   = m0_req | m1_req;
  assign pick      = (m0_req && m1_req) ? ~last_grant_q : m1_req;
  assign sel_we    = pick ? m1_we    : m0_we;
  assign sel_addr  = pick ? m1_addr  : m0_addr;
  assign sel_wdata = pick ? m1_wdata : m0_wdata;
  assign addr_off  = sel_addr - 32'(BASE_ADDR);
  assign sel_word  = addr_off[18:2];
  // Out-of-window address bits are deliberately dropped (word wraps at 17 bits).
  assign unused_addr_bits = ^{addr_off[31:19], addr_off[1:0]};

  logic phase_last;
  assign phase_last = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      rd_lo_q      <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      rd_lo_q      <= rd_lo_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    rd_lo_d      = rd_lo_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          // Latch the whole request so later changes on the port are ignored.
          gnt_d        = pick;
          last_grant_d = pick;
          we_d         = sel_we;
          word_d       = sel_word;
          wdata_d      = sel_wdata;
          cnt_d        = '0;
          state_d      = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = S_HIGH;
          if (!we_q) rd_lo_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (phase_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
          // Read data lands straight in the owner's output register so it is
          // valid for the whole DONE cycle; writes leave rdata untouched.
          if (!we_q) begin
            if (gnt_q) m1_rdata_d = {SRAM_DQ, rd_lo_q};
            else       m0_rdata_d = {SRAM_DQ, rd_lo_q};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // SRAM pins are decoded from registered state so an asynchronous reset
  // releases the bus (WE_N high, DQ floating) in the same instant.
  logic        in_phase;
  logic        drive_en;
  logic [15:0] dq_out;

  assign in_phase  = (state_q == S_LOW) || (state_q == S_HIGH);
  assign drive_en  = we_q && in_phase;
  assign dq_out    = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = drive_en ? dq_out : 16'hzzzz;
  assign SRAM_WE_N = ~drive_en;

  always_comb begin
    SRAM_ADDR = '0;
    case (state_q)
      S_LOW:   SRAM_ADDR = {word_q, 1'b0};
      S_HIGH:  SRAM_ADDR = {word_q, 1'b1};
      default: SRAM_ADDR = '0;
    endcase
  end

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  assign busy     = (state_q != S_IDLE);
  assign m0_ready = (state_q == S_DONE) && !gnt_q;
  assign m1_ready = (state_q == S_DONE) &&  gnt_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule
